credit_flit_sender: RTL and testbench
=====================================

Name: credit_flit_sender

Overview:
- Upstream transmitter for a credit-based NoC link. It feeds flits into a downstream input buffer of DEPTH entries.
- Tracks free downstream slots with a credit counter. Forwards flits only while credits remain. Regains one credit per credit return pulse from the downstream reader.
- Tracks wormhole packet framing (head/body/tail) and flags framing violations.
- Sits at each router output port, facing the neighbour's input buffer.

Parameters:
- FLIT_W, 16, flit payload width in bits.
- DEPTH, 8, downstream buffer depth; initial and maximum credit count.
- CNT_W, $clog2(DEPTH+1), credit counter width (localparam, derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  local side offers a flit.
- flit_i  in  FLIT_W  flit payload.
- flit_type_i  in  2  flit type (package encoding).
- ready_o  out  1  sender can accept a flit this cycle.
- valid_o  out  1  one-cycle write strobe to the downstream buffer.
- flit_o  out  FLIT_W  registered flit payload.
- flit_type_o  out  2  registered flit type.
- credit_i  in  1  one-cycle pulse: downstream freed one slot.
- credits_o  out  CNT_W  current credit count.
- in_packet_o  out  1  FSM is in IN_PACKET.
- proto_err_o  out  1  sticky framing-error flag.

Behaviour:
- Reset (async, rst=1):
  - credit_cnt=DEPTH, FSM=IDLE.
  - valid_o=0, flit_o=0, flit_type_o=0, proto_err_o=0, ready_o=1 (DEPTH>0).
- ready_o = (credit_cnt != 0). It depends only on the registered count, never on credit_i in the same cycle.
- Accept = valid_i & ready_o. On the next edge:
  - flit_o and flit_type_o are loaded and valid_o=1 for exactly one cycle.
  - Latency: 1 cycle from accept to valid_o.
- No accept in a cycle → valid_o=0 on the next edge. flit_o holds its last value.
- Back-to-back accepts produce consecutive valid_o cycles (full throughput while credits > 0).
- Credit update per edge:
  - accept only: -1.
  - credit_i only: +1.
  - both: unchanged.
  - neither: unchanged.
- Credit boundaries:
  - credit_cnt=0 with valid_i=1: not accepted; flit stays at input.
  - credit_i at credit_cnt=0 raises ready_o in the following cycle.
  - credit_i at credit_cnt=DEPTH with no accept: counter saturates at DEPTH (overflow is a downstream bug).
- Packet FSM (advances only on accept):
  - IDLE: HEAD → IN_PACKET; HEADTAIL → IDLE.
  - IN_PACKET: BODY → IN_PACKET; TAIL → IDLE.
- Framing errors: HEAD while IN_PACKET, or BODY/TAIL while IDLE.
  - The flit is still forwarded and credit is still consumed.
  - proto_err_o is set and stays set until rst.
  - The FSM follows the type: HEAD → IN_PACKET, TAIL → IDLE, BODY unchanged.
- Reset mid-packet: everything returns to reset values. Any in-flight valid_o is dropped. Re-synchronising the downstream buffer is the system's job (it is reset by the same rst).
- credits_o = credit_cnt, registered.

Optional Feature:
- Macro: CREDIT_SENDER_CHECK_EN.
- When defined:
  - Adds port credit_err_o (out, 1, sticky, cleared only by rst).
  - credit_err_o is set when credit_i arrives at credit_cnt=DEPTH without a same-cycle accept (overflow).
  - credit_err_o is also set if an accept is ever attempted at credit_cnt=0 (internal underflow guard; unreachable in a correct design).
- When undefined: no port, no check logic; saturation behaviour is unchanged.

Decomposition:
- Shared package noc_pkg:
  - flit_type_t, 2 bits: BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEADTAIL=2'b11.
  - pkt_state_t: IDLE, IN_PACKET.
  - Default FLIT_W and DEPTH constants, shared with the input buffer so both ends agree.
- One natural sub-module: credit_counter (up/down saturating counter with zero/full outputs). It is reusable by the buffer's credit-return side.

Test Plan:
- Reset then idle: credits_o=8, ready_o=1, valid_o=0, proto_err_o=0, in_packet_o=0.
- Send 8 flits back-to-back, no credits:
  - valid_o high for 8 consecutive cycles, each 1 cycle after accept.
  - credits_o goes 8→0 and ready_o=0.
  - A 9th flit held with valid_i=1 gets no valid_o.
- At credits=0, pulse credit_i once: credits_o=1 next cycle, ready_o=1; held flit sent; credits_o=0 again.
- At credits=3, same-cycle accept + credit_i: credits_o stays 3; valid_o=1 next cycle.
- Packet HEAD,BODY,BODY,TAIL: in_packet_o 0→1 after HEAD, stays 1 through BODYs, 0 after TAIL; proto_err_o=0.
- Framing and reset:
  - BODY while IDLE → proto_err_o=1, flit still forwarded, credits decremented.
  - rst asserted mid-packet clears proto_err_o and in_packet_o and restores credits_o=8.
  - With CREDIT_SENDER_CHECK_EN, credit_i at credits=8 → credit_err_o=1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, packet framing states and the
// default link sizing used by both the sender and the downstream input buffer.
package noc_pkg;

  localparam int FLIT_W_DEF = 16;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    BODY     = 2'b00,
    HEAD     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter that starts full and saturates at 0 and DEPTH.
// Simultaneous inc and dec cancel out.
module credit_counter #(
  parameter  int DEPTH = noc_pkg::DEPTH_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= MAX_CNT;
    end else if (inc && !dec && count != MAX_CNT) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);
  assign full = (count == MAX_CNT);

endmodule

// File: rtl/credit_flit_sender.sv
// Credit-based NoC link sender with wormhole framing checks.
// Optional macro CREDIT_SENDER_CHECK_EN adds the sticky credit_err_o port.
module credit_flit_sender
  import noc_pkg::*;
#(
  parameter  int FLIT_W = FLIT_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic [1:0]        flit_type_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [FLIT_W-1:0] flit_o,
  output logic [1:0]        flit_type_o,
  input  logic              credit_i,
  output logic [CNT_W-1:0]  credits_o,
  output logic              in_packet_o,
  output logic              proto_err_o
`ifdef CREDIT_SENDER_CHECK_EN
  ,
  output logic              credit_err_o
`endif
);

  pkt_state_t state_q, state_d;
  flit_type_t in_type;
  logic       accept;
  logic       frame_err;
  logic       cnt_zero;
  logic       cnt_full;

  assign in_type = flit_type_t'(flit_type_i);
  assign accept  = valid_i & ready_o;

  credit_counter #(.DEPTH(DEPTH)) u_credit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (credit_i),
    .dec   (accept),
    .count (credits_o),
    .zero  (cnt_zero),
    .full  (cnt_full)
  );

  assign ready_o     = ~cnt_zero;
  assign in_packet_o = (state_q == IN_PACKET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_o     <= 1'b0;
      flit_o      <= '0;
      flit_type_o <= 2'b00;
      proto_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_o <= accept;
      if (accept) begin
        flit_o      <= flit_i;
        flit_type_o <= flit_type_i;
      end
      if (frame_err) begin
        proto_err_o <= 1'b1;
      end
    end
  end

  // Framing violations still let the FSM follow the flit type so that the
  // tracker resynchronises to whatever framing the source is actually using.
  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          unique case (in_type)
            HEAD:     state_d = IN_PACKET;
            HEADTAIL: state_d = IDLE;
            BODY:     frame_err = 1'b1;
            TAIL: begin
              frame_err = 1'b1;
              state_d   = IDLE;
            end
            default:  state_d = IDLE;
          endcase
        end
        IN_PACKET: begin
          unique case (in_type)
            BODY: state_d = IN_PACKET;
            TAIL: state_d = IDLE;
            HEAD: begin
              frame_err = 1'b1;
              state_d   = IN_PACKET;
            end
            // A single-flit packet inside an open packet truncates it.
            HEADTAIL: begin
              frame_err = 1'b1;
              state_d   = IDLE;
            end
            default: state_d = IN_PACKET;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CREDIT_SENDER_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_err_o <= 1'b0;
    end else if ((credit_i && cnt_full && !accept) || (accept && cnt_zero)) begin
      credit_err_o <= 1'b1;
    end
  end
`else
  logic unused_full;
  assign unused_full = cnt_full;
`endif

endmodule

// File: tb/tb_credit_flit_sender.sv
// Directed self-checking bench for credit_flit_sender (DEPTH=8, FLIT_W=16).
// Works with or without CREDIT_SENDER_CHECK_EN defined.
module tb_credit_flit_sender;
  import noc_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [15:0] flit_i;
  logic [1:0]  flit_type_i;
  logic        ready_o;
  logic        valid_o;
  logic [15:0] flit_o;
  logic [1:0]  flit_type_o;
  logic        credit_i;
  logic [3:0]  credits_o;
  logic        in_packet_o;
  logic        proto_err_o;
`ifdef CREDIT_SENDER_CHECK_EN
  logic        credit_err_o;
`endif

  int total;
  int bad;

  credit_flit_sender #(.FLIT_W(16), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .flit_i       (flit_i),
    .flit_type_i  (flit_type_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .flit_o       (flit_o),
    .flit_type_o  (flit_type_o),
    .credit_i     (credit_i),
    .credits_o    (credits_o),
    .in_packet_o  (in_packet_o),
    .proto_err_o  (proto_err_o)
`ifdef CREDIT_SENDER_CHECK_EN
    ,
    .credit_err_o (credit_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [15:0] f, input logic [1:0] t,
                               input logic c);
    valid_i     = v;
    flit_i      = f;
    flit_type_i = t;
    credit_i    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    valid_i     = 1'b0;
    flit_i      = '0;
    flit_type_i = 2'b00;
    credit_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("rst_credits", 32'(credits_o), 32'd8);
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_flit", 32'(flit_o), 32'd0);
    checkOutput("rst_proto", 32'(proto_err_o), 32'd0);
    checkOutput("rst_inpkt", 32'(in_packet_o), 32'd0);
`ifdef CREDIT_SENDER_CHECK_EN
    checkOutput("rst_crediterr", 32'(credit_err_o), 32'd0);
`endif

    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, BODY, 1'b0);
    checkOutput("idle_credits", 32'(credits_o), 32'd8);
    checkOutput("idle_valid", 32'(valid_o), 32'd0);

    // Drain all eight credits back-to-back with single-flit packets.
    for (int i = 0; i < 8; i++) begin
      checkOutput("b2b_ready_pre", 32'(ready_o), 32'd1);
      applyStimulus(1'b1, 16'hA000 + 16'(i), HEADTAIL, 1'b0);
      checkOutput("b2b_valid", 32'(valid_o), 32'd1);
      checkOutput("b2b_flit", 32'(flit_o), 32'hA000 + 32'(i));
      checkOutput("b2b_credits", 32'(credits_o), 32'(7 - i));
    end
    checkOutput("empty_ready", 32'(ready_o), 32'd0);
    checkOutput("b2b_proto", 32'(proto_err_o), 32'd0);

    // Ninth flit is held at the input with no credits.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'hBEEF, HEADTAIL, 1'b0);
      checkOutput("held_valid", 32'(valid_o), 32'd0);
      checkOutput("held_credits", 32'(credits_o), 32'd0);
      checkOutput("held_flit", 32'(flit_o), 32'hA007);
    end

    applyStimulus(1'b1, 16'hBEEF, HEADTAIL, 1'b1);
    checkOutput("ret_credits", 32'(credits_o), 32'd1);
    checkOutput("ret_ready", 32'(ready_o), 32'd1);
    checkOutput("ret_valid", 32'(valid_o), 32'd0);
    applyStimulus(1'b1, 16'hBEEF, HEADTAIL, 1'b0);
    checkOutput("held_sent_valid", 32'(valid_o), 32'd1);
    checkOutput("held_sent_flit", 32'(flit_o), 32'hBEEF);
    checkOutput("held_sent_credits", 32'(credits_o), 32'd0);

    repeat (3) applyStimulus(1'b0, 16'h0, BODY, 1'b1);
    checkOutput("three_credits", 32'(credits_o), 32'd3);
    applyStimulus(1'b1, 16'hC0DE, HEADTAIL, 1'b1);
    checkOutput("both_credits", 32'(credits_o), 32'd3);
    checkOutput("both_valid", 32'(valid_o), 32'd1);
    checkOutput("both_flit", 32'(flit_o), 32'hC0DE);
    checkOutput("both_type", 32'(flit_type_o), 32'(HEADTAIL));

    repeat (5) applyStimulus(1'b0, 16'h0, BODY, 1'b1);
    checkOutput("refill_credits", 32'(credits_o), 32'd8);
    applyStimulus(1'b0, 16'h0, BODY, 1'b1);
    checkOutput("sat_credits", 32'(credits_o), 32'd8);
`ifdef CREDIT_SENDER_CHECK_EN
    checkOutput("overflow_crediterr", 32'(credit_err_o), 32'd1);
`endif

    applyStimulus(1'b1, 16'h1111, HEAD, 1'b0);
    checkOutput("pkt_head_inpkt", 32'(in_packet_o), 32'd1);
    checkOutput("pkt_head_type", 32'(flit_type_o), 32'(HEAD));
    applyStimulus(1'b1, 16'h1112, BODY, 1'b0);
    checkOutput("pkt_body1_inpkt", 32'(in_packet_o), 32'd1);
    applyStimulus(1'b1, 16'h1113, BODY, 1'b0);
    checkOutput("pkt_body2_inpkt", 32'(in_packet_o), 32'd1);
    applyStimulus(1'b1, 16'h1114, TAIL, 1'b0);
    checkOutput("pkt_tail_inpkt", 32'(in_packet_o), 32'd0);
    checkOutput("pkt_tail_type", 32'(flit_type_o), 32'(TAIL));
    checkOutput("pkt_proto", 32'(proto_err_o), 32'd0);
    checkOutput("pkt_credits", 32'(credits_o), 32'd4);

    applyStimulus(1'b1, 16'h2222, BODY, 1'b0);
    checkOutput("ferr_proto", 32'(proto_err_o), 32'd1);
    checkOutput("ferr_valid", 32'(valid_o), 32'd1);
    checkOutput("ferr_flit", 32'(flit_o), 32'h2222);
    checkOutput("ferr_credits", 32'(credits_o), 32'd3);
    checkOutput("ferr_inpkt", 32'(in_packet_o), 32'd0);

    applyStimulus(1'b1, 16'h3333, HEAD, 1'b0);
    checkOutput("mid_inpkt", 32'(in_packet_o), 32'd1);
    checkOutput("mid_proto_sticky", 32'(proto_err_o), 32'd1);
    applyStimulus(1'b1, 16'h4444, BODY, 1'b0);
    checkOutput("mid_valid", 32'(valid_o), 32'd1);
    checkOutput("mid_credits", 32'(credits_o), 32'd1);

    // Asynchronous reset in the middle of a packet with valid_o in flight.
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(valid_o), 32'd0);
    checkOutput("arst_proto", 32'(proto_err_o), 32'd0);
    checkOutput("arst_inpkt", 32'(in_packet_o), 32'd0);
    checkOutput("arst_credits", 32'(credits_o), 32'd8);
    checkOutput("arst_flit", 32'(flit_o), 32'd0);
`ifdef CREDIT_SENDER_CHECK_EN
    checkOutput("arst_crediterr", 32'(credit_err_o), 32'd0);
`endif
    valid_i  = 1'b0;
    credit_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, BODY, 1'b0);
    checkOutput("post_ready", 32'(ready_o), 32'd1);
    checkOutput("post_credits", 32'(credits_o), 32'd8);
    checkOutput("post_valid", 32'(valid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
